// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// the default sizing parameters.
package uart_tx_arb_pkg;

  localparam int NREQ_DEF     = 4;
  localparam int DW_DEF       = 8;
  localparam int START_TO_DEF = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester with req set, scanning
// upward from ptr and wrapping past NREQ-1 back to 0.
module rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  // Scan the requesters in priority order starting at ptr.
  always_comb begin
    int c;
    c     = 0;
    valid = 1'b0;
    idx   = ptr;
    for (int k = 0; k < NREQ; k++) begin
      c = int'(ptr) + k;
      if (c >= NREQ) c = c - NREQ;
      if (!valid && req[c]) begin
        valid = 1'b1;
        idx   = IW'(c);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates several character requesters onto one UART transmitter.
// Round-robin grant in IDLE, start handshake with timeout, wait for the
// frame to finish, then a single ack pulse to the granted requester.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter  int NREQ     = NREQ_DEF,
  parameter  int DW       = DW_DEF,
  parameter  int START_TO = START_TO_DEF,
  localparam int IW       = $clog2(NREQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  output logic               tx_start,
  output logic [DW-1:0]      tx_data,
  input  logic               tx_busy,
  output logic [IW-1:0]      grant_id,
  output logic               active,
  output logic               err_timeout
);

  localparam int          TW       = $clog2(START_TO + 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(START_TO - 1);

  arb_state_t    state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [IW-1:0] gid_nxt;
  logic [DW-1:0] data_nxt;
  logic          pick_vld;
  logic [IW-1:0] pick_idx;

  // Round-robin successor of a requester index.
  function automatic logic [IW-1:0] next_id(input logic [IW-1:0] id);
    if (int'(id) == NREQ - 1) return '0;
    return id + 1'b1;
  endfunction

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // State, pointer, counter and latched grant registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      tcnt     <= '0;
      grant_id <= '0;
      tx_data  <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      tcnt     <= tcnt_nxt;
      grant_id <= gid_nxt;
      tx_data  <= data_nxt;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    tcnt_nxt    = '0;
    gid_nxt     = grant_id;
    data_nxt    = tx_data;
    tx_start    = 1'b0;
    ack         = '0;
    err_timeout = 1'b0;
    active      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          gid_nxt   = pick_idx;
          data_nxt  = req_data[int'(pick_idx)*DW +: DW];
          state_nxt = START;
        end
      end
      START: begin
        tx_start = 1'b1;
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (tcnt == TCNT_LAST) begin
          // Transmitter never answered: drop this grant, move on without ack.
          err_timeout = 1'b1;
          ptr_nxt     = next_id(grant_id);
          state_nxt   = IDLE;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nxt = RELEASE;
      end
      RELEASE: begin
        ack[grant_id] = 1'b1;
        ptr_nxt       = next_id(grant_id);
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of transfers driven through a small
// transmitter model, plus hand-written reset sequences.
module tb_uart_tx_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        err_timeout;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter #(.NREQ(4), .DW(8), .START_TO(64)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .active      (active),
    .err_timeout (err_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [31:0] data2;
    int          chg_at;
    int          delay;
    int          len;
    bit          keep;
    bit          drop;
    logic [1:0]  gid;
    logic [7:0]  dat;
    bit          to;
  } xfer_t;

  xfer_t tbl[13];

  function automatic xfer_t mk(input logic [3:0] r, input logic [31:0] d,
                               input logic [31:0] d2, input int chg,
                               input int dly, input int len, input bit keep,
                               input bit drop, input logic [1:0] g,
                               input logic [7:0] dat, input bit to);
    xfer_t x;
    x.req = r; x.data = d; x.data2 = d2; x.chg_at = chg; x.delay = dly;
    x.len = len; x.keep = keep; x.drop = drop; x.gid = g; x.dat = dat; x.to = to;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic run_xfer(input int n, input xfer_t v);
    bit          started = 0, done = 0, data_bad = 0, both_bad = 0;
    int          since = 0, ack_cnt = 0, to_cnt = 0, to_since = -1;
    logic [3:0]  ack_val = '0;
    req      = v.req;
    req_data = v.data;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      tick();
      if (!started && tx_start) begin
        started = 1;
        since   = 0;
      end else if (started) begin
        since++;
      end
      tx_busy = started && (since >= v.delay) && (since < v.delay + v.len);
      if (started && v.chg_at > 0 && since == v.chg_at) req_data = v.data2;
      if (started && v.drop && since == 0) req = '0;
      #1;
      if (active && tx_data !== v.dat) data_bad = 1;
      if ($countones(ack) > 1 || (ack != 0 && err_timeout)) both_bad = 1;
      if (ack != 0) begin
        ack_cnt++;
        ack_val = ack;
        if (!v.keep) req = req & ~ack;
      end
      if (err_timeout) begin
        to_cnt++;
        to_since = since;
      end
      if (started && !active && (ack_cnt > 0 || to_cnt > 0)) done = 1;
    end
    tx_busy = 1'b0;
    chk($sformatf("r%0d_done", n), 32'(done), 32'd1);
    chk($sformatf("r%0d_gid", n), 32'(grant_id), 32'(v.gid));
    chk($sformatf("r%0d_data_stable", n), 32'(data_bad), 32'd0);
    chk($sformatf("r%0d_ack_excl", n), 32'(both_bad), 32'd0);
    chk($sformatf("r%0d_ack_cnt", n), 32'(ack_cnt), v.to ? 32'd0 : 32'd1);
    if (!v.to) chk($sformatf("r%0d_ack_bit", n), 32'(ack_val), 32'(4'b0001 << v.gid));
    chk($sformatf("r%0d_timeout_cnt", n), 32'(to_cnt), v.to ? 32'd1 : 32'd0);
    if (v.to) chk($sformatf("r%0d_timeout_cycle", n), 32'(to_since), 32'd63);
  endtask

  initial begin
    bit ack_seen;
    // Held request 1111 over five transfers: 0,1,2,3 then 0 again.
    tbl[0]  = mk(4'b1111, 32'h4433_2211, 32'h0, 0, 0,   5,  1, 0, 2'd0, 8'h11, 0);
    tbl[1]  = mk(4'b1111, 32'h4433_2211, 32'h0, 0, 1,   3,  1, 0, 2'd1, 8'h22, 0);
    tbl[2]  = mk(4'b1111, 32'h4433_2211, 32'h0, 0, 3,   8,  1, 0, 2'd2, 8'h33, 0);
    tbl[3]  = mk(4'b1111, 32'h4433_2211, 32'h0, 0, 2,   2,  1, 0, 2'd3, 8'h44, 0);
    tbl[4]  = mk(4'b1111, 32'h4433_2211, 32'h0, 0, 4,   4,  1, 0, 2'd0, 8'h11, 0);
    // Single requester 2, long frame.
    tbl[5]  = mk(4'b0100, 32'h00A5_0000, 32'h0, 0, 3,   160, 0, 0, 2'd2, 8'hA5, 0);
    // ptr is 3 here: only req[0] must wrap to 0.
    tbl[6]  = mk(4'b0001, 32'h0000_0077, 32'h0, 0, 3,   6,  0, 0, 2'd0, 8'h77, 0);
    // ptr is 1: requesters 2 and 3 pending, 2 wins.
    tbl[7]  = mk(4'b1100, 32'hBBAA_0000, 32'h0, 0, 1,   4,  0, 0, 2'd2, 8'hAA, 0);
    // req_data changes mid-frame; tx_data must stay 3C.
    tbl[8]  = mk(4'b0010, 32'h0000_3C00, 32'h0000_FF00, 5, 2, 20, 0, 0, 2'd1, 8'h3C, 0);
    // Transmitter never goes busy: timeout, no ack.
    tbl[9]  = mk(4'b1000, 32'h5A00_0000, 32'h0, 0, 1000, 1, 0, 0, 2'd3, 8'h5A, 1);
    // After timeout of 3, ptr is 0: requester 0 beats 3.
    tbl[10] = mk(4'b1001, 32'h9900_0066, 32'h0, 0, 2,   3,  0, 0, 2'd0, 8'h66, 0);
    // Busy on the first START cycle, and grantee drops req after grant.
    tbl[11] = mk(4'b0010, 32'h0000_E100, 32'h0, 0, 0,   5,  0, 1, 2'd1, 8'hE1, 0);
    // After a reset ptr is 0 again: requester 1 beats 2.
    tbl[12] = mk(4'b0110, 32'h00D0_0B00, 32'h0, 0, 2,   3,  0, 0, 2'd1, 8'h0B, 0);

    reset = 1'b1; req = '0; req_data = '0; tx_busy = 1'b0;
    repeat (3) tick();
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err_timeout", 32'(err_timeout), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) run_xfer(i, tbl[i]);

    // Reset during WAIT_DONE aborts without ack.
    req = 4'b0100; req_data = 32'h00C7_0000;
    tick();
    for (int k = 0; k < 10 && !tx_start; k++) tick();
    chk("wd_tx_start", 32'(tx_start), 32'd1);
    tx_busy = 1'b1;
    tick();
    chk("wd_in_wait", 32'({active, tx_start}), 32'b10);
    chk("wd_grant", 32'(grant_id), 32'd2);
    reset = 1'b1;
    tick();
    chk("wdrst_active", 32'(active), 32'd0);
    chk("wdrst_tx_start", 32'(tx_start), 32'd0);
    chk("wdrst_ack", 32'(ack), 32'd0);
    chk("wdrst_err_timeout", 32'(err_timeout), 32'd0);
    chk("wdrst_grant_id", 32'(grant_id), 32'd0);
    chk("wdrst_tx_data", 32'(tx_data), 32'd0);
    reset = 1'b0; tx_busy = 1'b0; req = '0;
    ack_seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ack != 0) ack_seen = 1;
    end
    chk("wdrst_no_ack", 32'(ack_seen), 32'd0);

    run_xfer(12, tbl[12]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
